// File: rtl/mips_regfile_sb.sv
// MIPS register file with two bypassed read ports, primary and late write ports,
// and a per-register busy scoreboard that drives read-hazard flags for stall logic.
module mips_regfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] read_reg_1,
    input  logic [ADDR_WIDTH-1:0] read_reg_2,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    input  logic                  signal_reg_write,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  late_write,
    input  logic [ADDR_WIDTH-1:0] late_reg,
    input  logic [DATA_WIDTH-1:0] late_data,
    input  logic                  busy_set,
    input  logic [ADDR_WIDTH-1:0] busy_set_reg,
    output logic                  hazard_1,
    output logic                  hazard_2,
    output logic [ADDR_WIDTH:0]   pending_count,
    output logic                  write_conflict
);

    localparam int   DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic ZERO_EN = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [ADDR_WIDTH:0]   pending_count_q;
    logic [ADDR_WIDTH:0]   pending_count_d;
    logic                  write_conflict_q;
    logic                  write_conflict_d;

    logic pw_eff;
    logic lw_eff;
    logic bs_eff;
    logic cnt_inc;
    logic cnt_dec;

    // A request aimed at a hardwired-zero register is dropped everywhere.
    assign pw_eff = signal_reg_write && !(ZERO_EN && (write_reg == '0));
    assign lw_eff = late_write && !(ZERO_EN && (late_reg == '0));
    assign bs_eff = busy_set && !(ZERO_EN && (busy_set_reg == '0));

    // Clear first, then set, so a new issue returning-in-the-same-cycle keeps the bit.
    always_comb begin
        busy_d = busy_q;
        if (lw_eff) begin
            busy_d[late_reg] = 1'b0;
        end
        if (bs_eff) begin
            busy_d[busy_set_reg] = 1'b1;
        end
    end

    assign cnt_inc = bs_eff && !busy_q[busy_set_reg];
    assign cnt_dec = lw_eff && busy_q[late_reg] && !(bs_eff && (busy_set_reg == late_reg));

    // The count mirrors busy-bit population, so it is bounded by DEPTH and cannot wrap.
    assign pending_count_d  = pending_count_q
                            + (ADDR_WIDTH + 1)'(cnt_inc)
                            - (ADDR_WIDTH + 1)'(cnt_dec);
    assign write_conflict_d = pw_eff && lw_eff && (write_reg == late_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q           <= '0;
            pending_count_q  <= '0;
            write_conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (lw_eff && (late_reg == ADDR_WIDTH'(i))) begin
                    regs_q[i] <= late_data;
                end else if (pw_eff && (write_reg == ADDR_WIDTH'(i))) begin
                    regs_q[i] <= write_data;
                end
            end
            busy_q           <= busy_d;
            pending_count_q  <= pending_count_d;
            write_conflict_q <= write_conflict_d;
        end
    end

    // Read ports: late result beats pipeline write beats stored value.
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
        logic [ADDR_WIDTH-1:0] idx;
        logic                  idx_zero;
        logic                  late_hit;
        logic                  prim_hit;
        logic [DATA_WIDTH-1:0] data;
        logic                  hazard;

        assign idx      = (gi == 0) ? read_reg_1 : read_reg_2;
        assign idx_zero = ZERO_EN && (idx == '0);
        assign late_hit = lw_eff && (late_reg == idx);
        assign prim_hit = pw_eff && (write_reg == idx);
        assign data     = idx_zero ? '0
                        : late_hit ? late_data
                        : prim_hit ? write_data
                        : regs_q[idx];
        assign hazard   = busy_q[idx] && !late_hit && !idx_zero;
    end

    assign read_data_1    = g_read[0].data;
    assign read_data_2    = g_read[1].data;
    assign hazard_1       = g_read[0].hazard;
    assign hazard_2       = g_read[1].hazard;
    assign pending_count  = pending_count_q;
    assign write_conflict = write_conflict_q;

endmodule
